// File: rtl/instr_encode_loader.sv
// Sequential program loader: packs decoded instruction fields into 32-bit core ISA words
// and writes them to consecutive instruction-memory addresses from a programmable base.
module instr_encode_loader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  length,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_shamt,
    input  logic [4:0]        in_aluop,
    input  logic [16:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              wrapped,
    output logic [CNT_W-1:0]  count
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccept = 2'd1;
    localparam logic [1:0] StWrite  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [ADDR_W-1:0] AddrOne = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CntOne  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              wrapped_q, wrapped_d;
    logic [31:0]       data_q, data_d;
    logic              done_q, done_d;
    logic [31:0]       enc_word;

    always_comb begin
        enc_word = 32'd0;
        case (in_kind)
            2'd0:    enc_word = {5'b00000, in_rd, in_rs, in_rt, in_shamt, in_aluop, 2'b00};
            2'd1:    enc_word = {5'b00101, in_rd, in_rs, in_imm};
            2'd2:    enc_word = {5'b00111, in_rd, in_rs, in_imm};
            default: enc_word = {5'b01000, in_rd, in_rs, in_imm};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rem_d     = rem_q;
        count_d   = count_q;
        wrapped_d = wrapped_q;
        data_d    = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d    = base_addr;
                    rem_d     = length;
                    count_d   = '0;
                    wrapped_d = 1'b0;
                    state_d   = (length == '0) ? StDone : StAccept;
                end
            end
            StAccept: begin
                if (in_valid) begin
                    data_d  = enc_word;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                // Address counter wraps naturally; flag the rollover from the all-ones address.
                addr_d  = addr_q + AddrOne;
                count_d = count_q + CntOne;
                rem_d   = rem_q - CntOne;
                if (&addr_q) begin
                    wrapped_d = 1'b1;
                end
                state_d = (rem_q == CntOne) ? StDone : StAccept;
            end
            default: state_d = StIdle;
        endcase
    end

    // The done pulse is registered off the DONE state, so it lands in the following cycle.
    assign done_d = (state_q == StDone);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            wrapped_q <= 1'b0;
            data_q    <= 32'd0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
            data_q    <= data_d;
            done_q    <= done_d;
        end
    end

    assign in_ready  = (state_q == StAccept);
    assign imem_we   = (state_q == StWrite);
    assign busy      = (state_q != StIdle);
    assign imem_addr = addr_q;
    assign imem_data = data_q;
    assign done      = done_q;
    assign wrapped   = wrapped_q;
    assign count     = count_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Self-checking bench for instr_encode_loader: directed scenarios plus randomized sessions
// compared against an arithmetic encoding model and an expected address/data list.
module tb_instr_encode_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic [11:0] length = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [4:0]  in_rd = '0, in_rs = '0, in_rt = '0, in_shamt = '0, in_aluop = '0;
    logic [16:0] in_imm = '0;
    logic        imem_we;
    logic [11:0] imem_addr;
    logic [31:0] imem_data;
    logic        busy, done, wrapped;
    logic [11:0] count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ready_cnt = 0;
    int wr_addr[$];
    int unsigned wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];

    instr_encode_loader #(.ADDR_W(12), .CNT_W(12)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind), .in_rd(in_rd),
        .in_rs(in_rs), .in_rt(in_rt), .in_shamt(in_shamt), .in_aluop(in_aluop),
        .in_imm(in_imm), .imem_we(imem_we), .imem_addr(imem_addr), .imem_data(imem_data),
        .busy(busy), .done(done), .wrapped(wrapped), .count(count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (imem_we) begin
            wr_addr.push_back(int'(imem_addr));
            wr_data.push_back(imem_data);
            wr_cyc.push_back(cyc);
        end
        if (done) done_cyc.push_back(cyc);
        if (in_ready) ready_cnt++;
    end

    function automatic int unsigned model_enc(int k, int rd, int rs, int rt, int sh, int op,
                                              int imm);
        int unsigned opc;
        if (k == 0)
            return rd * (2 ** 22) + rs * (2 ** 17) + rt * (2 ** 12) + sh * (2 ** 7) + op * 4;
        opc = (k == 1) ? 5 : (k == 2) ? 7 : 8;
        return opc * (2 ** 27) + rd * (2 ** 22) + rs * (2 ** 17) + (imm % (2 ** 17));
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        done_cyc.delete();
    endtask

    // Raise start for one cycle; returns the negedge cycle index at which it was raised.
    task automatic pulse_start(input int base, input int len, output int at);
        @(negedge clock);
        start = 1'b1;
        base_addr = 12'(base);
        length = 12'(len);
        at = cyc;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Hold in_valid until a handshake edge; returns just after that edge.
    task automatic send(input int k, input int rd, input int rs, input int rt, input int sh,
                        input int op, input int imm, output bit timeout);
        timeout = 1'b1;
        @(negedge clock);
        in_kind = 2'(k); in_rd = 5'(rd); in_rs = 5'(rs); in_rt = 5'(rt);
        in_shamt = 5'(sh); in_aluop = 5'(op); in_imm = 17'(imm);
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (in_ready) begin
                @(posedge clock);
                #1;
                timeout = 1'b0;
                break;
            end
            @(negedge clock);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done_cyc.size() == 0; i++) @(negedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        total++;
        if ({in_ready, imem_we, busy, done, wrapped} !== 5'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=00000",
                            {in_ready, imem_we, busy, done, wrapped});
        end
        total++;
        if (imem_addr !== 12'h0 || imem_data !== 32'h0 || count !== 12'h0) begin
            bad++; $display("FAIL reset_regs got addr=%h data=%h count=%0d want 0/0/0",
                            imem_addr, imem_data, count);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single();
        int s;
        bit to;
        clear_log();
        pulse_start(12'h010, 1, s);
        send(0, 3, 1, 2, 0, 0, 17'h1ABCD, to);
        wait_done();
        total++;
        if (to || wr_addr.size() != 1) begin
            bad++; $display("FAIL single_nwrites got=%0d want=1 timeout=%0d", wr_addr.size(), to);
        end else begin
            total++;
            if (wr_addr[0] != 'h010 || wr_data[0] != 32'h00C22000) begin
                bad++; $display("FAIL single_word got=%h@%h want=00c22000@010",
                                wr_data[0], wr_addr[0]);
            end
            total++;
            if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[0] + 2) begin
                bad++; $display("FAIL single_done_lat got=%0d pulses want one at write+2",
                                done_cyc.size());
            end
        end
        total++;
        if (count !== 12'd1 || busy !== 1'b0) begin
            bad++; $display("FAIL single_count got=%0d busy=%b want=1 busy=0", count, busy);
        end
    endtask

    task automatic test_back_to_back();
        int s;
        bit t0, t1, t2;
        int unsigned exp[3] = '{32'h2901FFFF, 32'h394C0008, 32'h41C40004};
        clear_log();
        pulse_start(12'h200, 3, s);
        send(1, 4, 0, 9, 9, 9, 17'h1FFFF, t0);
        send(2, 5, 6, 1, 1, 1, 8, t1);
        send(3, 7, 2, 3, 3, 3, 4, t2);
        wait_done();
        total++;
        if (t0 || t1 || t2 || wr_addr.size() != 3) begin
            bad++; $display("FAIL b2b_nwrites got=%0d want=3", wr_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wr_addr[i] != 'h200 + i || wr_data[i] != exp[i]) begin
                    bad++; $display("FAIL b2b_word%0d got=%h@%h want=%h@%h", i, wr_data[i],
                                    wr_addr[i], exp[i], 'h200 + i);
                end
            end
            total++;
            if (wr_cyc[1] - wr_cyc[0] != 2 || wr_cyc[2] - wr_cyc[1] != 2) begin
                bad++; $display("FAIL b2b_spacing got=%0d,%0d want=2,2",
                                wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
            end
        end
        total++;
        if (count !== 12'd3 || wrapped !== 1'b0) begin
            bad++; $display("FAIL b2b_count got=%0d wrapped=%b want=3 0", count, wrapped);
        end
    endtask

    task automatic test_wrap();
        int s;
        bit t0, t1;
        clear_log();
        pulse_start(12'hFFF, 2, s);
        send(1, 1, 1, 0, 0, 0, 1, t0);
        send(1, 2, 2, 0, 0, 0, 2, t1);
        wait_done();
        total++;
        if (t0 || t1 || wr_addr.size() != 2 || wr_addr[0] != 'hFFF || wr_addr[1] != 0) begin
            bad++; $display("FAIL wrap_addrs got n=%0d want FFF then 000", wr_addr.size());
        end
        total++;
        if (wrapped !== 1'b1 || count !== 12'd2) begin
            bad++; $display("FAIL wrap_flags got wrapped=%b count=%0d want=1 2", wrapped, count);
        end
    endtask

    task automatic test_zero_len();
        int s, r0;
        clear_log();
        r0 = ready_cnt;
        pulse_start(12'h123, 0, s);
        repeat (6) @(negedge clock);
        total++;
        if (wr_addr.size() != 0 || ready_cnt != r0) begin
            bad++; $display("FAIL zero_len_activity got writes=%0d ready=%0d want=0 0",
                            wr_addr.size(), ready_cnt - r0);
        end
        total++;
        if (done_cyc.size() != 1 || done_cyc[0] != s + 2) begin
            bad++; $display("FAIL zero_len_done got pulses=%0d want one at start+2",
                            done_cyc.size());
        end
        total++;
        if (count !== 12'd0 || wrapped !== 1'b0) begin
            bad++; $display("FAIL zero_len_count got=%0d wrapped=%b want=0 0", count, wrapped);
        end
    endtask

    task automatic test_stall();
        int s, s2;
        bit to;
        int okcnt;
        clear_log();
        pulse_start(12'h040, 1, s);
        okcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (in_ready === 1'b1 && imem_we === 1'b0) okcnt++;
            if (i == 1) begin
                start = 1'b1; base_addr = 12'h300; length = 12'd5;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (okcnt != 5 || wr_addr.size() != 0) begin
            bad++; $display("FAIL stall_hold got ready_cycles=%0d writes=%0d want=5 0",
                            okcnt, wr_addr.size());
        end
        send(0, 1, 2, 3, 4, 1, 17'h1FFFF, to);
        wait_done();
        total++;
        if (to || wr_addr.size() != 1 || wr_addr[0] != 'h040 || wr_data[0] != 32'h00443204) begin
            bad++; $display("FAIL stall_word got n=%0d want 00443204@040", wr_addr.size());
        end
        total++;
        if (count !== 12'd1 || done_cyc.size() != 1) begin
            bad++; $display("FAIL stall_ignore_start got count=%0d dones=%0d want=1 1",
                            count, done_cyc.size());
        end
        repeat (3) @(negedge clock);
        total++;
        if (imem_data !== 32'h00443204 || imem_addr !== 12'h041) begin
            bad++; $display("FAIL stall_hold_outputs got data=%h addr=%h want=00443204 041",
                            imem_data, imem_addr);
        end
        s2 = s;
    endtask

    task automatic test_abort();
        int s;
        bit to, t0, t1;
        clear_log();
        pulse_start(12'h100, 4, s);
        send(1, 1, 1, 0, 0, 0, 5, to);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({in_ready, imem_we, busy, done, wrapped} !== 5'b0 || imem_addr !== 12'h0 ||
            imem_data !== 32'h0 || count !== 12'h0) begin
            bad++; $display("FAIL abort_async got flags=%b addr=%h data=%h count=%0d want 0",
                            {in_ready, imem_we, busy, done, wrapped}, imem_addr, imem_data,
                            count);
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        clear_log();
        pulse_start(12'h2A0, 2, s);
        #1;
        total++;
        if (count !== 12'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL abort_restart got count=%0d busy=%b want=0 1", count, busy);
        end
        send(3, 9, 8, 0, 0, 0, 7, t0);
        send(2, 10, 11, 0, 0, 0, 3, t1);
        wait_done();
        total++;
        if (t0 || t1 || wr_addr.size() != 2 || wr_addr[0] != 'h2A0 || wr_addr[1] != 'h2A1 ||
            wr_data[0] != model_enc(3, 9, 8, 0, 0, 0, 7) ||
            wr_data[1] != model_enc(2, 10, 11, 0, 0, 0, 3) || count !== 12'd2) begin
            bad++; $display("FAIL abort_reload got n=%0d count=%0d want 2 writes at 2A0",
                            wr_addr.size(), count);
        end
    endtask

    task automatic test_random();
        for (int sess = 0; sess < 8; sess++) begin
            int base, len, s;
            int unsigned exp_data[$];
            bit exp_wrap, to, any_to;
            base = ($urandom_range(0, 2) == 0) ? $urandom_range(12'hFFA, 12'hFFF)
                                               : $urandom_range(0, 12'hFFF);
            len = $urandom_range(1, 6);
            exp_wrap = 1'b0;
            any_to = 1'b0;
            exp_data.delete();
            clear_log();
            pulse_start(base, len, s);
            for (int i = 0; i < len; i++) begin
                int k, rd, rs, rt, sh, op, imm;
                k = $urandom_range(0, 3); rd = $urandom_range(0, 31); rs = $urandom_range(0, 31);
                rt = $urandom_range(0, 31); sh = $urandom_range(0, 31);
                op = $urandom_range(0, 31); imm = $urandom_range(0, 17'h1FFFF);
                exp_data.push_back(model_enc(k, rd, rs, rt, sh, op, imm));
                if ((base + i) % 4096 == 4095) exp_wrap = 1'b1;
                repeat ($urandom_range(0, 3)) @(negedge clock);
                send(k, rd, rs, rt, sh, op, imm, to);
                any_to |= to;
            end
            wait_done();
            total++;
            if (any_to || wr_addr.size() != len) begin
                bad++; $display("FAIL rand%0d_nwrites got=%0d want=%0d", sess, wr_addr.size(),
                                len);
            end else begin
                for (int i = 0; i < len; i++) begin
                    total++;
                    if (wr_addr[i] != (base + i) % 4096 || wr_data[i] != exp_data[i]) begin
                        bad++; $display("FAIL rand%0d_word%0d got=%h@%h want=%h@%h", sess, i,
                                        wr_data[i], wr_addr[i], exp_data[i], (base + i) % 4096);
                    end
                end
                total++;
                if (done_cyc.size() != 1 || done_cyc[0] != wr_cyc[len - 1] + 2) begin
                    bad++; $display("FAIL rand%0d_done got pulses=%0d want one at write+2",
                                    sess, done_cyc.size());
                end
            end
            total++;
            if (count !== 12'(len) || wrapped !== exp_wrap) begin
                bad++; $display("FAIL rand%0d_status got count=%0d wrapped=%b want=%0d %b",
                                sess, count, wrapped, len, exp_wrap);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_zero_len();
        test_stall();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Sequential program loader that feeds the processor's instruction memory. It is the encode-side counterpart of the core's opcode decoder.
- Accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit words in the core ISA format.
- Writes the words to consecutive imem addresses starting at a programmable base.
- Used by the boot/test harness to place programs before releasing the core from reset.

Parameters:
- ADDR_W, 12, imem word-address width; the address counter wraps modulo 2^ADDR_W.
- CNT_W, 12, width of the length and count fields.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  one-cycle pulse; begins a load session; sampled only in IDLE.
- base_addr  in  ADDR_W  first imem address for the session.
- length  in  CNT_W  number of instructions to load.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  loader can accept a bundle.
- in_kind  in  2  0=R-type, 1=ADDI, 2=SW, 3=LW.
- in_rd, in_rs, in_rt, in_shamt, in_aluop  in  5 each  instruction fields.
- in_imm  in  17  immediate, two's complement.
- imem_we  out  1  instruction-memory write strobe.
- imem_addr  out  ADDR_W  write address.
- imem_data  out  32  encoded word.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at session end.
- wrapped  out  1  sticky; address counter passed 2^ADDR_W-1 during the session.
- count  out  CNT_W  words written in the current or last session.

Behaviour:
- Reset (asynchronous, reset=0) forces: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_data=0, busy=0, done=0, wrapped=0, count=0.
- Reset mid-session aborts the session immediately. No further imem writes; words already written stay in memory.
- Encoding is by in_kind; unused bits are 0.
  - R (kind 0): [31:27]=00000, [26:22]=rd, [21:17]=rs, [16:12]=rt, [11:7]=shamt, [6:2]=aluop, [1:0]=00.
  - ADDI (kind 1): opcode 00101; [26:22]=rd, [21:17]=rs, [16:0]=imm.
  - SW (kind 2): opcode 00111; same layout as ADDI.
  - LW (kind 3): opcode 01000; same layout as ADDI.
  - I-type kinds ignore rt, shamt and aluop. R-type ignores imm.
- State machine:
  - IDLE: in_ready=0. On start:
    - load addr=base_addr, remaining=length, count=0, wrapped=0.
    - go to ACCEPT, or to DONE if length==0.
  - ACCEPT: in_ready=1. On in_valid & in_ready:
    - register the encoded word into imem_data and go to WRITE.
    - without in_valid, stay in ACCEPT indefinitely.
  - WRITE: in_ready=0, imem_we=1 for exactly this cycle, imem_addr=current addr.
    - at the edge: addr+=1, count+=1, remaining-=1.
    - if addr was 2^ADDR_W-1, addr becomes 0 and wrapped is set.
    - remaining reaching 0 -> DONE; otherwise -> ACCEPT.
  - DONE: done=1 for one cycle, then IDLE.
- Throughput: one instruction per 2 cycles minimum.
- Latency: imem write occurs the cycle after handshake acceptance.
- start while busy is ignored; the session is unaffected.
- imem_data and imem_addr hold their last values outside WRITE. Only imem_we qualifies them.
- count and wrapped hold after DONE until the next accepted start.
- in_ready is a registered state decode; it does not depend combinationally on in_valid.

Test Plan:
- Reset then start, base=0x010, length=1; bundle R rd=3 rs=1 rt=2 shamt=0 aluop=0 -> one imem write at 0x010 with data 0x00C22000; done pulses 2 cycles after that write; count=1.
- Session length=3 with back-to-back valid bundles:
  - ADDI rd=4 rs=0 imm=0x1FFFF -> 0x2901FFFF at base.
  - SW rd=5 rs=6 imm=8 -> 0x394C0008 at base+1.
  - LW rd=7 rs=2 imm=4 -> 0x41C40004 at base+2.
  - Required: writes spaced exactly 2 cycles apart.
- base=0xFFF (ADDR_W=12), length=2 -> writes at 0xFFF then 0x000; wrapped=1 after the session; count=2.
- length=0 -> no imem_we; done pulses 2 cycles after start; in_ready never asserted.
- in_valid withheld 5 cycles in ACCEPT -> no write and in_ready stays 1. A start pulse in that window is ignored. R-type aluop=00001 then encodes bit 2 set (0x...04).
- Assert reset during WRITE of a 4-word session -> all outputs reset asynchronously. A new start afterwards loads cleanly from the new base_addr with count restarting at 0.
